// File: rtl/mda_pkg.sv
// Shared types, constants and address helpers for the MDA text terminal.
package mda_pkg;

    localparam int MDA_COLS   = 80;
    localparam int MDA_ROWS   = 25;
    localparam int MDA_CELL_W = 9;
    localparam int MDA_CELL_H = 14;

    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_FF = 8'h0C;

    typedef enum logic [1:0] {CLEAR, IDLE, CLEAR_LINE} term_state_t;

    typedef logic [6:0]  col_t;
    typedef logic [4:0]  row_t;
    typedef logic [10:0] caddr_t;

    // Logical row -> physical row under the scroll offset (top).
    function automatic row_t map_row(row_t r, row_t top, int rows);
        logic [5:0] s;
        s = {1'b0, r} + {1'b0, top};
        if (s >= 6'(rows)) s = s - 6'(rows);
        return s[4:0];
    endfunction

    // Linear buffer address of a physical (row, col) cell.
    function automatic caddr_t cell_addr(row_t r, col_t c, int cols);
        return caddr_t'(r) * caddr_t'(cols) + caddr_t'(c);
    endfunction

endpackage

// File: rtl/mda_char_ram.sv
// Character buffer: one write port, one registered read port.
// A same-cycle read of the written address returns the old contents.
module mda_char_ram
    import mda_pkg::*;
#(
    parameter int DEPTH = MDA_COLS * MDA_ROWS
) (
    input  logic        clk,
    input  logic        we,
    input  logic [10:0] waddr,
    input  logic [7:0]  wdata,
    input  logic [10:0] raddr,
    output logic [7:0]  rdata
);

    logic [7:0] mem [DEPTH];

    // Write and registered read share the edge; NBA ordering gives read-before-write.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/mda_text_terminal.sv
// Byte-stream text terminal: control-code interpreter, scrolling 80x25
// character buffer and a display read port with one cycle of latency.
module mda_text_terminal
    import mda_pkg::*;
#(
    parameter int         COLS  = MDA_COLS,
    parameter int         ROWS  = MDA_ROWS,
    parameter logic [7:0] BLANK = 8'h20
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_char,
    input  logic [6:0] rd_col,
    input  logic [4:0] rd_row,
    output logic [7:0] rd_char,
    output logic [6:0] cursor_col,
    output logic [4:0] cursor_row,
    output logic       busy
);

    localparam caddr_t LAST_ADDR = caddr_t'(COLS * ROWS - 1);
    localparam caddr_t LAST_LINE = caddr_t'(COLS - 1);
    localparam col_t   LAST_COL  = col_t'(COLS - 1);
    localparam row_t   LAST_ROW  = row_t'(ROWS - 1);

    term_state_t state_q;
    caddr_t      idx_q;
    caddr_t      line_base_q;
    col_t        col_q;
    row_t        row_q;
    row_t        top_q;

    logic        xfer;
    logic        is_print;
    logic        col_wrap;
    logic        do_nl;

    logic        wr_en;
    caddr_t      wr_addr;
    logic [7:0]  wr_data;

    logic        rd_oor;
    caddr_t      rd_addr;
    logic        rd_oor_q;
    logic        rd_live_q;
    logic [7:0]  ram_rdata;

    assign in_ready   = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign cursor_col = col_q;
    assign cursor_row = row_q;

    assign xfer     = in_valid && (state_q == IDLE);
    assign is_print = !(in_char inside {CH_CR, CH_LF, CH_BS, CH_FF});
    assign col_wrap = (col_q == LAST_COL);
    // Explicit LF, or a printable byte landing in the last column.
    assign do_nl    = xfer && ((in_char == CH_LF) || (is_print && col_wrap));

    // Terminal FSM: clears, cursor movement and scrolling.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= CLEAR;
            idx_q       <= '0;
            line_base_q <= '0;
            col_q       <= '0;
            row_q       <= '0;
            top_q       <= '0;
        end else begin
            case (state_q)
                CLEAR: begin
                    if (idx_q == LAST_ADDR) begin
                        state_q <= IDLE;
                        idx_q   <= '0;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                CLEAR_LINE: begin
                    if (idx_q == LAST_LINE) begin
                        state_q <= IDLE;
                        idx_q   <= '0;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                IDLE: begin
                    if (in_valid) begin
                        case (in_char)
                            CH_CR: col_q <= '0;
                            CH_LF: ;
                            CH_BS: if (col_q != '0) col_q <= col_q - 1'b1;
                            CH_FF: begin
                                col_q   <= '0;
                                row_q   <= '0;
                                top_q   <= '0;
                                idx_q   <= '0;
                                state_q <= CLEAR;
                            end
                            default: col_q <= col_wrap ? '0 : col_q + 1'b1;
                        endcase
                        if (do_nl) begin
                            if (row_q != LAST_ROW) begin
                                row_q <= row_q + 1'b1;
                            end else begin
                                // Old top physical row becomes the new bottom line.
                                top_q       <= (top_q == LAST_ROW) ? '0 : top_q + 1'b1;
                                line_base_q <= cell_addr(top_q, '0, COLS);
                                idx_q       <= '0;
                                state_q     <= CLEAR_LINE;
                            end
                        end
                    end
                end
                default: state_q <= CLEAR;
            endcase
        end
    end

    // Write port: clear sweeps own it while busy, otherwise printable bytes.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = idx_q;
        wr_data = BLANK;
        case (state_q)
            CLEAR:      wr_en = 1'b1;
            CLEAR_LINE: begin
                wr_en   = 1'b1;
                wr_addr = line_base_q + idx_q;
            end
            IDLE: begin
                if (xfer && is_print) begin
                    wr_en   = 1'b1;
                    wr_addr = cell_addr(map_row(row_q, top_q, ROWS), col_q, COLS);
                    wr_data = in_char;
                end
            end
            default: ;
        endcase
    end

    // Display address; out-of-range requests are steered to a safe address and masked later.
    always_comb begin
        rd_oor  = (rd_col >= col_t'(COLS)) || (rd_row >= row_t'(ROWS));
        rd_addr = rd_oor ? '0 : cell_addr(map_row(rd_row, top_q, ROWS), rd_col, COLS);
    end

    // Read-side qualifiers aligned with the RAM's registered output.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_live_q <= 1'b0;
            rd_oor_q  <= 1'b0;
        end else begin
            rd_live_q <= 1'b1;
            rd_oor_q  <= rd_oor;
        end
    end

    assign rd_char = !rd_live_q ? 8'h00 : (rd_oor_q ? BLANK : ram_rdata);

    mda_char_ram #(
        .DEPTH (COLS * ROWS)
    ) u_ram (
        .clk   (clock),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (rd_addr),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_mda_text_terminal.sv
// Directed bench for the MDA text terminal.
module tb_mda_text_terminal;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_char;
    logic [6:0] rd_col;
    logic [4:0] rd_row;
    logic [7:0] rd_char;
    logic [6:0] cursor_col;
    logic [4:0] cursor_row;
    logic       busy;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    mda_text_terminal dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_char    (in_char),
        .rd_col     (rd_col),
        .rd_row     (rd_row),
        .rd_char    (rd_char),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present an address at a negedge, return rd_char at the following negedge.
    task automatic rd(input int c, input int r, output logic [7:0] d);
        rd_col = 7'(c);
        rd_row = 5'(r);
        @(posedge clock);
        @(negedge clock);
        d = rd_char;
    endtask

    // Hold the byte until accepted; returns at the negedge after the transfer.
    task automatic send(input logic [7:0] b);
        int n;
        in_valid = 1'b1;
        in_char  = b;
        n = 0;
        while (!in_ready && n < 5000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 5000) chk("send_timeout", 32'(n), 0);
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    // Count posedges until busy falls; also flags in_ready seen while busy.
    task automatic busy_len(output int n, output int rdy_seen);
        n = 0;
        rdy_seen = 0;
        while (busy && n < 5000) begin
            if (in_ready) rdy_seen++;
            @(posedge clock);
            @(negedge clock);
            n++;
        end
    endtask

    initial begin
        logic [7:0] d;
        int n, rs, bad;

        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_char  = 8'h00;
        rd_col   = '0;
        rd_row   = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_busy", busy, 1);
        chk("rst_ready", in_ready, 0);
        chk("rst_rdchar", rd_char, 8'h00);
        reset_n = 1'b1;

        busy_len(n, rs);
        chk("clr_len", n, 2000);
        chk("clr_ready", rs, 0);
        chk("clr_cur_col", cursor_col, 0);
        chk("clr_cur_row", cursor_row, 0);
        bad = 0;
        for (int r = 0; r < 25; r++)
            for (int c = 0; c < 80; c++) begin
                rd(c, r, d);
                if (d != 8'h20) bad++;
            end
        chk("clr_all_blank", bad, 0);

        // Plain characters.
        send(8'h41);
        send(8'h42);
        chk("ab_col", cursor_col, 2);
        chk("ab_row", cursor_row, 0);
        rd(0, 0, d); chk("rd_0_0", d, 8'h41);
        rd(1, 0, d); chk("rd_1_0", d, 8'h42);
        rd(0, 25, d); chk("oor_row", d, 8'h20);
        rd(80, 0, d); chk("oor_col", d, 8'h20);

        // Full-row write wraps to the next line without stalling.
        send(8'h0D);
        chk("cr_col", cursor_col, 0);
        bad = 0;
        for (int i = 0; i < 80; i++) begin
            if (!in_ready) bad++;
            send(8'h2A);
        end
        chk("row_ready", bad, 0);
        chk("wrap_col", cursor_col, 0);
        chk("wrap_row", cursor_row, 1);
        bad = 0;
        for (int c = 0; c < 80; c++) begin
            rd(c, 0, d);
            if (d != 8'h2A) bad++;
        end
        chk("row0_star", bad, 0);
        rd(0, 1, d); chk("row1_blank", d, 8'h20);

        // Mark row 1 and row 24 so the scroll can be observed.
        send(8'h43);
        for (int i = 0; i < 23; i++) send(8'h0A);
        send(8'h0D);
        for (int i = 0; i < 5; i++) send(8'h78);
        chk("pre_col", cursor_col, 5);
        chk("pre_row", cursor_row, 24);

        send(8'h0A);
        busy_len(n, rs);
        chk("scroll_len", n, 80);
        chk("scroll_col", cursor_col, 5);
        chk("scroll_row", cursor_row, 24);
        rd(0, 0, d); chk("scr_0_0", d, 8'h43);
        rd(1, 0, d); chk("scr_1_0", d, 8'h20);
        rd(4, 23, d); chk("scr_4_23", d, 8'h78);
        rd(5, 23, d); chk("scr_5_23", d, 8'h20);
        bad = 0;
        for (int c = 0; c < 80; c++) begin
            rd(c, 24, d);
            if (d != 8'h20) bad++;
        end
        chk("scr_bottom_blank", bad, 0);

        // Backspace and carriage return.
        send(8'h0D);
        send(8'h08);
        chk("bs0_col", cursor_col, 0);
        chk("bs0_row", cursor_row, 24);
        send(8'h61); send(8'h62); send(8'h63);
        chk("abc_col", cursor_col, 3);
        send(8'h08);
        chk("bs3_col", cursor_col, 2);
        rd(2, 24, d); chk("bs_cell", d, 8'h63);
        rd(0, 24, d); chk("wr_map", d, 8'h61);
        send(8'h0D);
        chk("cr2_col", cursor_col, 0);

        // Reset in the middle of a line clear with a byte held pending.
        send(8'h0A);
        chk("cl2_busy", busy, 1);
        repeat (10) @(negedge clock);
        in_valid = 1'b1;
        in_char  = 8'h55;
        reset_n  = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        chk("mrst_row", cursor_row, 0);
        chk("mrst_col", cursor_col, 0);
        busy_len(n, rs);
        chk("mrst_len", n, 2000);
        chk("mrst_ready", rs, 0);
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        chk("held_col", cursor_col, 1);
        chk("held_row", cursor_row, 0);
        rd(0, 0, d); chk("held_cell", d, 8'h55);
        rd(1, 0, d); chk("held_next", d, 8'h20);
        rd(0, 1, d); chk("mrst_row1", d, 8'h20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
